mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single-port synchronous instruction/data RAM between the instruction-fetch unit and the load/store unit. Grants at most one request per cycle and drives the RAM port. Routes the 1-cycle-latency read data back to the requester that issued the read. Load/store has priority; a starvation counter guarantees fetch forward progress.

Parameters:
ADDR_W, 32, byte-address width of both requesters
DATA_W, 32, data width; byte-enable width is DATA_W/8
MEM_AW, 12, RAM word-index width
STARVE_MAX, 4, consecutive LS grants with IF waiting before IF is forced

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req_valid  in  1  fetch request
if_req_addr  in  ADDR_W  fetch byte address
if_req_ready  out  1  fetch request accepted this cycle
if_rsp_valid  out  1  fetch data valid
if_rsp_data  out  DATA_W  fetched word
ls_req_valid  in  1  load/store request
ls_req_we  in  1  1 = store, 0 = load
ls_req_be  in  DATA_W/8  store byte enables
ls_req_addr  in  ADDR_W  LS byte address
ls_req_wdata  in  DATA_W  store data
ls_req_ready  out  1  LS request accepted this cycle
ls_rsp_valid  out  1  load data valid / store acknowledge
ls_rsp_data  out  DATA_W  load data; 0 for store ack
mem_en  out  1  RAM access enable
mem_we  out  DATA_W/8  RAM byte write enables
mem_addr  out  MEM_AW  RAM word index = granted addr[MEM_AW+1:2]
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en

Behaviour:
- Grant is combinational on current inputs. The accepted request appears on the mem_* port in the same cycle.
- Grant rules:
  - Only IF valid: grant IF.
  - Only LS valid: grant LS.
  - Both valid: grant LS unless starve_cnt == STARVE_MAX, then grant IF.
  - Neither valid: no grant.
- if_req_ready and ls_req_ready are one-hot or zero; never both 1.
- mem_en = any grant. mem_we = ls_req_be only when LS granted and ls_req_we = 1, else 0. mem_wdata = ls_req_wdata when LS is granted, else 0.
- addr[1:0] is ignored. Bits above MEM_AW+1 are ignored, so addresses wrap modulo RAM size.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments when LS is granted while IF is valid.
  - Clears on any IF grant or when IF is not valid.
  - Saturates at STARVE_MAX.
- Response pipeline: registers rsp_owner (none/IF/LS) and rsp_is_store.
  - Cycle N+1 after an IF grant: if_rsp_valid = 1, if_rsp_data = mem_rdata.
  - Cycle N+1 after an LS load grant: ls_rsp_valid = 1, ls_rsp_data = mem_rdata.
  - Cycle N+1 after an LS store grant: ls_rsp_valid = 1, ls_rsp_data = 0.
  - Response data is routed combinationally from mem_rdata, gated by the registered owner. Data outputs are 0 when the matching valid is 0.
- Back-to-back grants every cycle are supported, giving full throughput. Responses have no backpressure; requesters must accept them.
- Reset (rst = 0, asynchronous):
  - rsp_owner = none, starve_cnt = 0.
  - All ready, rsp_valid and mem_en outputs are forced to 0.
  - All data outputs are 0.
- Reset asserted mid-operation discards any pending response. No response is issued after reset deasserts.
- First grant is possible in the first clock edge after rst deasserts.

Test Plan:
- IF only, if_req_addr = 0x0, 0x4, 0x8 on consecutive cycles, RAM preloaded with word i = i -> if_req_ready = 1 each cycle; if_rsp_data = 0, 1, 2 one cycle later each.
- LS store addr 0x10, be = 4'b0011, wdata = 0xAABBCCDD, then load 0x10 over a prior word of 0 -> mem_we = 0011; store ack with ls_rsp_data = 0; load returns 0x0000CCDD.
- IF and LS both valid continuously, STARVE_MAX = 4 -> grant pattern LS, LS, LS, LS, IF repeating; readies are never both 1.
- Address wrap: LS load at address 4 << MEM_AW (word index 2^MEM_AW) -> mem_addr = 0; returns word 0.
- rst pulled low for 2 ns right after an IF grant, before the next edge -> if_rsp_valid stays 0; all outputs 0 during reset; starve_cnt = 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port RAM between instruction fetch and load/store,
// with load/store priority, fetch starvation relief and 1-cycle response routing.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  input  logic                ls_req_we,
  input  logic [DATA_W/8-1:0] ls_req_be,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_t;

  owner_t           rsp_owner;
  logic             rsp_is_store;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_if;
  logic             grant_ls;

  // Grants are held off while reset is asserted so the RAM port stays quiet.
  assign starved  = (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_ls = rst & ls_req_valid & ~(if_req_valid & starved);
  assign grant_if = rst & if_req_valid & ~grant_ls;

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign mem_en       = grant_if | grant_ls;
  assign mem_we       = (grant_ls && ls_req_we) ? ls_req_be : '0;
  assign mem_wdata    = grant_ls ? ls_req_wdata : '0;

  always_comb begin
    mem_addr = '0;
    if (grant_ls) begin
      mem_addr = ls_req_addr[MEM_AW+1:2];
    end else if (grant_if) begin
      mem_addr = if_req_addr[MEM_AW+1:2];
    end
  end

  // Byte offset and bits above the RAM size are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[ADDR_W-1:MEM_AW+2], if_req_addr[1:0],
                              ls_req_addr[ADDR_W-1:MEM_AW+2], ls_req_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_owner    <= OWN_NONE;
      rsp_is_store <= 1'b0;
      starve_cnt   <= '0;
    end else begin
      if (grant_ls) begin
        rsp_owner <= OWN_LS;
      end else if (grant_if) begin
        rsp_owner <= OWN_IF;
      end else begin
        rsp_owner <= OWN_NONE;
      end
      rsp_is_store <= grant_ls & ls_req_we;

      if (!if_req_valid || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_ls && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Read data is steered straight from the RAM; stores acknowledge with zero data.
  assign if_rsp_valid = (rsp_owner == OWN_IF);
  assign ls_rsp_valid = (rsp_owner == OWN_LS);
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign ls_rsp_data  = (ls_rsp_valid && !rsp_is_store) ? mem_rdata : '0;

endmodule
